// File: rtl/fifo_axis_reader_pkg.sv
// Shared types for the FIFO-to-AXI4-Stream reader: FSM state encoding and the
// {last, data} entry layout held in the output skid buffer.
package fifo_axis_reader_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic                      last;
    logic [DATA_WIDTH_DEF-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/fifo_axis_reader_skid.sv
// Two-entry output buffer: pushes land at the tail, the head drives the
// stream and leaves on a TVALID & TREADY handshake.
module axis_skid_buf
  import fifo_axis_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  last_in,
  output logic [1:0]            occ,
  output logic                  tvalid,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast
);

  logic [DATA_WIDTH:0] ent0_q, ent0_d;
  logic [DATA_WIDTH:0] ent1_q, ent1_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_WIDTH:0] in_w;
  logic                pop;

  assign in_w = {last_in, data_in};
  assign pop  = (occ_q != 2'd0) && tready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          ent0_d = in_w;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          ent0_d = in_w;
        end else if (push) begin
          ent1_d = in_w;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      2'd2: begin
        // Full: the reader never pushes here, so only a pop can move the queue.
        if (pop) begin
          ent0_d = ent1_q;
          if (push) begin
            ent1_d = in_w;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ    = occ_q;
  assign tvalid = (occ_q != 2'd0);
  assign tdata  = ent0_q[DATA_WIDTH-1:0];
  assign tlast  = ent0_q[DATA_WIDTH];

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a show-ahead FIFO into one AXI4-Stream packet of a programmed length,
// marking the final beat with TLAST and pulsing DONE when it has been accepted.
module fifo_axis_reader
  import fifo_axis_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [LEN_WIDTH-1:0]  LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FIFO_RD_CMD,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  fsm_state_t           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]           occ;
  logic                 rd_cmd;
  logic                 last_in;
  logic                 hs;

  // Pop decision uses only registered state and the FIFO flag, never TREADY.
  assign rd_cmd  = (state_q == RUN) && !FIFO_EMPTY && (pop_cnt_q != len_q) && (occ != 2'd2);
  assign last_in = (len_q != '0) && (pop_cnt_q == len_q - ONE);
  assign hs      = M_AXIS_TVALID && M_AXIS_TREADY;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pop_cnt_d  = pop_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          len_d      = LEN;
          pop_cnt_d  = '0;
          beat_cnt_d = '0;
          state_d    = (LEN != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (rd_cmd) begin
          pop_cnt_d = pop_cnt_q + ONE;
        end
        if (hs) begin
          beat_cnt_d = beat_cnt_q + ONE;
          if (beat_cnt_q == len_q - ONE) begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign FIFO_RD_CMD = rd_cmd;
  assign BUSY        = (state_q != IDLE);
  assign DONE        = (state_q == FIN);

  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (CLK),
    .rst    (RESET),
    .push   (rd_cmd),
    .data_in(FIFO_RD_DATA),
    .last_in(last_in),
    .occ    (occ),
    .tvalid (M_AXIS_TVALID),
    .tready (M_AXIS_TREADY),
    .tdata  (M_AXIS_TDATA),
    .tlast  (M_AXIS_TLAST)
  );

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
- Drains the read interface of the register FIFO in the mlp_conv datapath and emits the words as an AXI4-Stream master packet.
- Packet length is programmed per transfer; TLAST is asserted on the final beat.
- Sits between an output FIFO, such as the conv/MLP result FIFO, and the DMA S2MM stream.
- FIFO side is show-ahead: read data is valid whenever the FIFO is not empty, and a read command advances the FIFO at the next edge.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and TDATA.
- LEN_WIDTH, 16, width of the beat-count field; maximum packet length is 2^LEN_WIDTH-1.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a transfer when idle.
- LEN  in  LEN_WIDTH  beats in the transfer; sampled when START is accepted.
- BUSY  out  1  high from an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the transfer completes.
- FIFO_RD_CMD  out  1  pop request to the FIFO.
- FIFO_RD_DATA  in  DATA_WIDTH  FIFO front word; valid when FIFO_EMPTY=0.
- FIFO_EMPTY  in  1  FIFO empty flag.
- M_AXIS_TDATA  out  DATA_WIDTH  stream data.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TLAST  out  1  last beat of the packet.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE, counters=0, output buffer empty.
  - BUSY=0, DONE=0, FIFO_RD_CMD=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: START=1 latches LEN into len_reg and clears pop_cnt and beat_cnt.
    - LEN!=0: next state RUN.
    - LEN=0: next state FIN; no beats and no pops.
  - IDLE: START=0 stays in IDLE.
  - RUN → FIN on the edge where the handshake with beat_cnt==len_reg-1 occurs.
  - FIN lasts one cycle with DONE=1, then returns to IDLE.
  - START in RUN or FIN is ignored.
- BUSY = (state != IDLE), registered state decode.
- Output buffer: 2-entry skid buffer holding {last, data}, with occupancy occ in {0,1,2}.
- FIFO_RD_CMD = (state==RUN) & ~FIFO_EMPTY & (pop_cnt != len_reg) & (occ != 2).
  - Combinational from registered state only.
  - Never depends on M_AXIS_TREADY.
- Pop capture:
  - When FIFO_RD_CMD=1, FIFO_RD_DATA is written into the buffer at that same edge.
  - The captured entry's last bit = (pop_cnt == len_reg-1).
  - pop_cnt increments.
- Stream side:
  - TVALID = (occ != 0).
  - TDATA and TLAST come from the head entry.
  - A handshake (TVALID & TREADY) removes the head entry and increments beat_cnt.
- Simultaneous pop and handshake: occ is unchanged; ordering is preserved by pushing to the tail and removing from the head.
- Throughput: with FIFO non-empty and TREADY held high, one beat per cycle.
- Latency: FIFO_EMPTY falling at cycle N (FSM in RUN) → TVALID=1 at N+1.
- AXI rule: once TVALID=1, TDATA, TLAST and TVALID hold stable until the handshake.
- Underflow: FIFO_EMPTY=1 suppresses pops; the block stalls indefinitely with no error.
- Overflow of the transfer: no pops occur after pop_cnt reaches len_reg. Words beyond LEN remain in the FIFO.
- Reset mid-transfer: buffered words are discarded and the FSM returns to IDLE. Words already popped are lost, which is acceptable.
- Widths:
  - pop_cnt and beat_cnt are LEN_WIDTH bits.
  - The len_reg-1 comparison is evaluated only when len_reg != 0.

Decomposition:
- Package fifo_axis_reader_pkg:
  - state enum fsm_state_t (IDLE, RUN, FIN).
  - buffer entry struct {last, data} parameterised via DATA_WIDTH localparam default.
- Sub-module axis_skid_buf:
  - 2-entry buffer with push/data_in/last_in, occ, and TVALID/TREADY head.
  - Async active-high reset.

Test Plan:
- Reset check: assert RESET mid-cycle → all outputs 0 immediately; BUSY=0 and DONE=0 after deassert.
- Basic burst: FIFO prefilled with 0xA0,0xA1,0xA2,0xA3; LEN=4; TREADY=1.
  - Four consecutive beats 0xA0..0xA3, TLAST only on 0xA3.
  - DONE one cycle after the last handshake.
  - Exactly 4 FIFO_RD_CMD cycles.
- Backpressure: 8 words, LEN=8, TREADY toggles 1,0,0,1,...
  - Data is in order and stable while stalled.
  - FIFO_RD_CMD=0 whenever occ=2.
  - No word lost or duplicated.
- Slow source: LEN=3, FIFO receives one word every 4 cycles.
  - FIFO_RD_CMD never high while FIFO_EMPTY=1.
  - Each TVALID rises 1 cycle after FIFO_EMPTY falls.
  - TLAST on the 3rd beat.
- LEN=0 and START-while-busy:
  - START with LEN=0 → BUSY for 1 cycle, DONE pulse, no TVALID, no pops.
  - START during RUN → ignored; the packet length is unchanged.
- Mid-transfer reset: LEN=6 with RESET after 2 beats.
  - Outputs clear.
  - A new START with LEN=2 delivers the next 2 FIFO words with TLAST on the 2nd.
